complex_for_sequencer: RTL and testbench

- Multi-cycle, shared implementation of the converging dual-index accumulation loop: i counts up from a start value, j counts down from an end value, and a 16-bit accumulator is updated on each step.
- Executes one loop iteration per clock instead of unrolling the whole loop combinationally.
- Two requesters share the single datapath through a round-robin arbiter.
- Results return over a valid/ready channel, tagged with the requester id.

---
 rtl/complex_for_sequencer_if.sv | 27 ++
 rtl/complex_for_sequencer.sv | 131 +++++++++++++
 tb/tb_complex_for_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/complex_for_sequencer_if.sv
// Request/response bundle for the shared dual-index accumulation sequencer.
// The master side drives requests and result accept; the slave side is the sequencer.
interface complex_for_sequencer_if #(
  parameter int ACC_W = 16,
  parameter int IDX_W = 8
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*IDX_W-1:0] req_start;
  logic [2*IDX_W-1:0] req_end;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [ACC_W-1:0]   rsp_accum;
  logic [IDX_W-1:0]   rsp_iters;
  logic               busy;

  modport master (
    output req_valid, req_start, req_end, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_accum, rsp_iters, busy
  );

  modport slave (
    input  req_valid, req_start, req_end, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_accum, rsp_iters, busy
  );
endinterface

// File: rtl/complex_for_sequencer.sv
// Round-robin shared datapath running the converging i-up/j-down accumulation loop, one step per clock.
// Result valid N+1 edges after accept; result held in DONE until rsp_ready, no grant during that handshake.
module complex_for_sequencer #(
  parameter int ACC_W = 16,
  parameter int IDX_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  complex_for_sequencer_if.slave bus
);
  localparam int IW = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    i_q, i_d, j_q, j_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] iters_q, iters_d;
  logic             id_q, id_d;
  logic             last_grant_q, last_grant_d;
  logic             rsp_id_q, rsp_id_d;
  logic [ACC_W-1:0] rsp_accum_q, rsp_accum_d;
  logic [IDX_W-1:0] rsp_iters_q, rsp_iters_d;

  logic             grant;
  logic             accept;
  logic [IDX_W-1:0] start_sel, end_sel;
  logic [ACC_W-1:0] i_ext, j_ext, t;

  always_comb begin
    grant = 1'b0;
    case (bus.req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant_q;
      default: grant = 1'b0;
    endcase

    bus.req_ready = 2'b00;
    if (state_q == IDLE && bus.req_valid != 2'b00) begin
      bus.req_ready = grant ? 2'b10 : 2'b01;
    end
    accept = |(bus.req_valid & bus.req_ready);

    start_sel = grant ? bus.req_start[IDX_W +: IDX_W] : bus.req_start[0 +: IDX_W];
    end_sel   = grant ? bus.req_end[IDX_W +: IDX_W]   : bus.req_end[0 +: IDX_W];

    // i and j never exceed 256, so zero-extension into the accumulator width is exact.
    i_ext = ACC_W'(i_q);
    j_ext = ACC_W'(j_q);
    t     = (i_q < (j_q >> 1)) ? acc_q + i_ext : acc_q - j_ext;
  end

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    j_d          = j_q;
    acc_d        = acc_q;
    iters_d      = iters_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    rsp_accum_d  = rsp_accum_q;
    rsp_iters_d  = rsp_iters_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          i_d          = {1'b0, start_sel};
          j_d          = {1'b0, end_sel};
          acc_d        = '0;
          iters_d      = '0;
          id_d         = grant;
          last_grant_d = grant;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (i_q >= j_q) begin
          rsp_accum_d = acc_q;
          rsp_iters_d = iters_q;
          rsp_id_d    = id_q;
          state_d     = DONE;
        end else begin
          acc_d   = i_q[0] ? t - ACC_W'(1) : t + ACC_W'(1);
          i_d     = i_q + IW'(1);
          j_d     = j_q - IW'(1);
          iters_d = iters_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      i_q          <= '0;
      j_q          <= '0;
      acc_q        <= '0;
      iters_q      <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_id_q     <= 1'b0;
      rsp_accum_q  <= '0;
      rsp_iters_q  <= '0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      j_q          <= j_d;
      acc_q        <= acc_d;
      iters_q      <= iters_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      rsp_accum_q  <= rsp_accum_d;
      rsp_iters_q  <= rsp_iters_d;
    end
  end

  assign bus.rsp_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_accum = rsp_accum_q;
  assign bus.rsp_iters = rsp_iters_q;
endmodule

// File: tb/tb_complex_for_sequencer.sv
// Directed plus randomized bench for complex_for_sequencer against a loop-level reference model.
module tb_complex_for_sequencer;
  localparam int ACC_W = 16;
  localparam int IDX_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  complex_for_sequencer_if #(.ACC_W(ACC_W), .IDX_W(IDX_W)) bus ();

  complex_for_sequencer #(.ACC_W(ACC_W), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int st[2];
  int en[2];
  int last_g = 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: run the loop literally on integers, wrap the accumulator to 16 bits.
  function automatic void model(input int s, input int e, output int acc, output int n);
    int i, j, tt;
    i = s; j = e; acc = 0; n = 0;
    while (i < j) begin
      tt  = (i < j / 2) ? acc + i : acc - j;
      acc = ((i % 2) == 0) ? tt + 1 : tt - 1;
      acc = acc & 16'hFFFF;
      i++; j--; n++;
    end
  endfunction

  function automatic int pred_grant(input logic [1:0] v);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    return 1 - last_g;
  endfunction

  function automatic int closed_n(input int s, input int e);
    return (e > s) ? (e - s + 1) / 2 : 0;
  endfunction

  task automatic drive_ops();
    bus.req_start = {8'(st[1]), 8'(st[0])};
    bus.req_end   = {8'(en[1]), 8'(en[0])};
  endtask

  // Entered and left at a negedge. keep=1 holds req_valid and reloads operands after each accept.
  task automatic txn(input logic [1:0] vmask, input int bp, input bit keep);
    int g, acc_e, n_e, lat, s_used, e_used;
    bit got;
    logic [ACC_W-1:0] held_acc;
    logic [IDX_W-1:0] held_it;
    logic held_id;
    bus.rsp_ready = (bp == 0);
    drive_ops();
    bus.req_valid = vmask;
    g = pred_grant(vmask);
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      if (c == 0) #1; else @(negedge clk);
      if (bus.req_ready != 2'b00) begin
        got = 1'b1;
        check("grant", 32'(bus.req_ready), 32'(2'b01 << g));
      end
    end
    if (!got) check("grant_timeout", 32'(0), 32'(1));
    s_used = st[g]; e_used = en[g];
    last_g = g;
    model(s_used, e_used, acc_e, n_e);
    @(posedge clk); #1;
    if (!keep) bus.req_valid = 2'b00;
    else begin
      st[g] = $urandom_range(0, 60);
      en[g] = $urandom_range(0, 60);
      drive_ops();
    end
    lat = 0; got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (bus.rsp_valid) got = 1'b1;
      else check("ready_while_busy", 32'(bus.req_ready), 32'(0));
    end
    if (!got) check("rsp_timeout", 32'(0), 32'(1));
    check("latency", 32'(lat), 32'(closed_n(s_used, e_used) + 1));
    check("accum", 32'(bus.rsp_accum), 32'(acc_e));
    check("iters", 32'(bus.rsp_iters), 32'(n_e));
    check("rsp_id", 32'(bus.rsp_id), 32'(g));
    check("busy_done", 32'(bus.busy), 32'(1));
    held_acc = bus.rsp_accum; held_it = bus.rsp_iters; held_id = bus.rsp_id;
    for (int k = 0; k < bp; k++) begin
      @(posedge clk); @(negedge clk);
      check("bp_valid", 32'(bus.rsp_valid), 32'(1));
      check("bp_accum", 32'(bus.rsp_accum), 32'(held_acc));
      check("bp_iters", 32'(bus.rsp_iters), 32'(held_it));
      check("bp_id", 32'(bus.rsp_id), 32'(held_id));
      check("bp_no_accept", 32'(bus.req_ready), 32'(0));
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("no_grant_in_handshake", 32'(bus.req_ready), 32'(0));
    @(posedge clk); @(negedge clk);
    check("valid_drop", 32'(bus.rsp_valid), 32'(0));
    check("accum_hold", 32'(bus.rsp_accum), 32'(acc_e));
  endtask

  initial begin
    int k;
    bit got;
    bus.req_valid = 2'b00;
    bus.req_start = '0;
    bus.req_end   = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'(0));
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    check("rst_rsp_id", 32'(bus.rsp_id), 32'(0));
    check("rst_rsp_accum", 32'(bus.rsp_accum), 32'(0));
    check("rst_rsp_iters", 32'(bus.rsp_iters), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed test-plan cases.
    st[0] = 0; en[0] = 4; st[1] = 0; en[1] = 0;
    txn(2'b01, 0, 1'b0);
    check("tp_r0_accum", 32'(bus.rsp_accum), 32'h0000FFFD);
    check("tp_r0_iters", 32'(bus.rsp_iters), 32'd2);
    st[1] = 2; en[1] = 8;
    txn(2'b10, 0, 1'b0);
    check("tp_r1_accum", 32'(bus.rsp_accum), 32'h0000FFF6);
    check("tp_r1_iters", 32'(bus.rsp_iters), 32'd3);
    st[0] = 5; en[0] = 5;
    txn(2'b01, 0, 1'b0);
    check("tp_eq_accum", 32'(bus.rsp_accum), 32'd0);
    st[1] = 10; en[1] = 3;
    txn(2'b10, 0, 1'b0);
    check("tp_gt_iters", 32'(bus.rsp_iters), 32'd0);
    st[0] = 0; en[0] = 255;
    txn(2'b01, 0, 1'b0);
    check("tp_max_iters", 32'(bus.rsp_iters), 32'd128);

    // Backpressure in DONE.
    st[1] = 7; en[1] = 30;
    txn(2'b10, 5, 1'b0);

    // Randomized single-requester jobs.
    for (int n = 0; n < 10; n++) begin
      k = $urandom_range(0, 1);
      st[k] = $urandom_range(0, 255);
      en[k] = (n % 3 == 0) ? $urandom_range(0, 255) : st[k] + $urandom_range(0, 255 - st[k]);
      txn(2'(2'b01 << k), (n % 4 == 3) ? $urandom_range(1, 4) : 0, 1'b0);
    end

    // Both requesters continuously valid: grants must alternate.
    st[0] = $urandom_range(0, 60); en[0] = $urandom_range(0, 60);
    st[1] = $urandom_range(0, 60); en[1] = $urandom_range(0, 60);
    for (int n = 0; n < 4; n++) begin
      k = last_g;
      txn(2'b11, 0, 1'b1);
      check("alternate", 32'(last_g), 32'(1 - k));
    end
    bus.req_valid = 2'b00;
    @(negedge clk);

    // Reset in the middle of a long job.
    st[0] = 0; en[0] = 255;
    drive_ops();
    bus.req_valid = 2'b01;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (bus.req_ready[0]) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) check("mid_rst_grant_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    repeat (20) @(negedge clk);
    check("mid_rst_busy_before", 32'(bus.busy), 32'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'(0));
    check("mid_rst_valid", 32'(bus.rsp_valid), 32'(0));
    check("mid_rst_ready", 32'(bus.req_ready), 32'(0));
    check("mid_rst_accum", 32'(bus.rsp_accum), 32'(0));
    check("mid_rst_iters", 32'(bus.rsp_iters), 32'(0));
    check("mid_rst_id", 32'(bus.rsp_id), 32'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_g = 1;
    for (int c = 0; c < 140; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) check("post_rst_no_rsp", 32'(bus.rsp_valid), 32'(0));
    end
    check("post_rst_idle", 32'(bus.busy), 32'(0));
    st[1] = 1; en[1] = 20;
    txn(2'b10, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
